// File: rtl/edge_threshold.sv
// edge_threshold: saturates gradient magnitude, thresholds it against a per-frame level,
// zeroes the Sobel border and emits one registered pixel with raster markers.
module edge_threshold #(
   parameter int WIDTH_P   = 8,
   parameter int FRAME_W_P = 640,
   parameter int FRAME_H_P = 480
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [2*WIDTH_P-1:0]   mag_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [WIDTH_P-1:0]     threshold_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [WIDTH_P-1:0]     pix_o,
   output logic                   edge_o,
   output logic                   sof_o,
   output logic                   eol_o,
   output logic                   eof_o
);
   localparam int CW = $clog2(FRAME_W_P);
   localparam int RW = $clog2(FRAME_H_P);
   localparam logic [CW-1:0] COL_LAST = CW'(FRAME_W_P - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H_P - 1);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic [WIDTH_P-1:0]  thresh_q, thresh_d;
   logic [WIDTH_P-1:0]  pix_q, pix_d;
   logic                edge_q, edge_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;

   logic                accept, emit, first, col_last, row_last, border;
   logic [WIDTH_P-1:0]  sat, thresh_eff;

   assign valid_o    = (state_q == FULL);
   assign ready_o    = !valid_o || ready_i;
   assign accept     = valid_i && ready_o;
   assign emit       = valid_o && ready_i;
   assign col_last   = (col_q == COL_LAST);
   assign row_last   = (row_q == ROW_LAST);
   assign first      = (col_q == '0) && (row_q == '0);
   assign border     = (row_q == '0) || row_last || (col_q == '0) || col_last;
   assign sat        = (|mag_i[2*WIDTH_P-1:WIDTH_P]) ? '1 : mag_i[WIDTH_P-1:0];
   // The first pixel of a frame uses the live threshold since thresh_q is loaded on the same edge.
   assign thresh_eff = first ? threshold_i : thresh_q;

   assign pix_o = pix_q;
   assign edge_o = edge_q;
   assign sof_o = sof_q;
   assign eol_o = eol_q;
   assign eof_o = eof_q;

   always_comb begin
      state_d  = accept ? FULL : (emit ? EMPTY : state_q);
      col_d    = col_q;
      row_d    = row_q;
      thresh_d = thresh_q;
      pix_d    = pix_q;
      edge_d   = edge_q;
      sof_d    = sof_q;
      eol_d    = eol_q;
      eof_d    = eof_q;
      if (accept) begin
         col_d    = col_last ? '0 : col_q + CW'(1);
         row_d    = col_last ? (row_last ? '0 : row_q + RW'(1)) : row_q;
         thresh_d = first ? threshold_i : thresh_q;
         pix_d    = border ? '0 : sat;
         edge_d   = !border && (sat >= thresh_eff);
         sof_d    = first;
         eol_d    = col_last;
         eof_d    = col_last && row_last;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= EMPTY;
         col_q    <= '0;
         row_q    <= '0;
         thresh_q <= '0;
         pix_q    <= '0;
         edge_q   <= 1'b0;
         sof_q    <= 1'b0;
         eol_q    <= 1'b0;
         eof_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         thresh_q <= thresh_d;
         pix_q    <= pix_d;
         edge_q   <= edge_d;
         sof_q    <= sof_d;
         eol_q    <= eol_d;
         eof_q    <= eof_d;
      end
   end
endmodule

// File: tb/tb_edge_threshold.sv
// tb_edge_threshold: directed and random streams scored against a raster-index model of edge_threshold.
module tb_edge_threshold;
   localparam int W = 4, H = 3, WD = 8;

   typedef struct {
      logic [7:0] pix;
      logic       edg, sof, eol, eof;
   } item_t;

   logic        clk = 0, rst = 1, valid_i = 0, ready_i = 1;
   logic [15:0] mag_i = 0;
   logic [7:0]  threshold_i = 0;
   logic        ready_o, valid_o, edge_o, sof_o, eol_o, eof_o;
   logic [7:0]  pix_o;

   int checks = 0, errors = 0;
   int k = 0, edge_cnt = 0, eof_cnt = 0;
   logic [7:0] frame_thr = 0;
   item_t q[$];

   edge_threshold #(.WIDTH_P(WD), .FRAME_W_P(W), .FRAME_H_P(H)) dut (
      .clk_i(clk), .rst_i(rst), .mag_i(mag_i), .valid_i(valid_i), .ready_o(ready_o),
      .threshold_i(threshold_i), .valid_o(valid_o), .ready_i(ready_i), .pix_o(pix_o),
      .edge_o(edge_o), .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic item_t model(input int idx, input logic [15:0] m, input logic [7:0] thr);
      item_t it;
      int r = idx / W, c = idx % W;
      logic [7:0] s = (m > 16'd255) ? 8'hFF : m[7:0];
      logic [7:0] te = (idx == 0) ? thr : frame_thr;
      logic b = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
      it.pix = b ? 8'h00 : s;
      it.edg = !b && (s >= te);
      it.sof = (idx == 0);
      it.eol = (c == W - 1);
      it.eof = (idx == W * H - 1);
      return it;
   endfunction

   task automatic step(input logic v, input logic [15:0] m, input logic [7:0] thr,
                       input logic rdy, input logic r);
      logic acc, em;
      @(negedge clk);
      valid_i = v; mag_i = m; threshold_i = thr; ready_i = rdy; rst = r;
      #1;
      check("ready_o", ready_o, (q.size() == 0) || rdy);
      acc = v && ((q.size() == 0) || rdy);
      em  = (q.size() != 0) && rdy;
      if (!r && em && valid_o) begin
         edge_cnt += edge_o;
         eof_cnt  += eof_o;
      end
      @(posedge clk);
      #1;
      if (r) begin
         q.delete();
         k = 0;
         frame_thr = 0;
      end else begin
         if (em) void'(q.pop_front());
         if (acc) begin
            q.push_back(model(k, m, thr));
            if (k == 0) frame_thr = thr;
            k = (k + 1) % (W * H);
         end
      end
      check("valid_o", valid_o, q.size() != 0);
      if (q.size() != 0) begin
         check("pix_o", pix_o, q[0].pix);
         check("edge_o", edge_o, q[0].edg);
         check("sof_o", sof_o, q[0].sof);
         check("eol_o", eol_o, q[0].eol);
         check("eof_o", eof_o, q[0].eof);
      end
   endtask

   task automatic check_idle_zero();
      check("rst_valid", valid_o, 0);
      check("rst_pix", pix_o, 0);
      check("rst_flags", {edge_o, sof_o, eol_o, eof_o}, 0);
   endtask

   initial begin
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      check_idle_zero();
      edge_cnt = 0; eof_cnt = 0;
      for (int i = 0; i < W * H; i++) step(1, 16'h0050, 8'h40, 1, 0);
      step(0, 0, 8'h40, 1, 0);
      check("frame_edges", edge_cnt, 2);
      check("frame_eofs", eof_cnt, 1);
      for (int i = 0; i < W * H; i++) step(1, (i == 5) ? 16'h0123 : 16'h0050, 8'h40, 1, 0);
      for (int i = 0; i < W * H; i++)
         step(1, (i == 5) ? 16'h00FF : (i == 6) ? 16'h00FE : 16'h0010, 8'hFF, 1, 0);
      for (int i = 0; i < W * H; i++) step(1, 16'h0050, (i < 2) ? 8'h40 : 8'h90, 1, 0);
      for (int i = 0; i < W * H; i++) step(1, 16'h0050, 8'h90, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 16'h0060 + 16'(i), 8'h40, 1, 0);
      for (int i = 0; i < 5; i++) step(1, 16'h0070, 8'h40, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 16'h0080 + 16'(i), 8'h40, 1, 0);
      step(0, 0, 8'h40, 1, 0);
      for (int i = 0; i < 6; i++) step(1, 16'h0055, 8'h30, 1, 0);
      step(1, 16'h0055, 8'h30, 1, 1);
      check_idle_zero();
      for (int i = 0; i < W * H; i++) step(1, 16'h0055, 8'h30, 1, 0);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0,
              ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255)),
              8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
